logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit that generalises the single-bit two-input NAND primitive into a WIDTH-bit, eight-operation datapath with valid/ready flow control. Two registered stages, full throughput of one operation per cycle, and zero/all-ones result flags. It sits between an operand source and a result consumer as the logic half of the datapath; the arithmetic half is a separate block.

---
 rtl/logic_pipe_if.sv | 38 +++
 rtl/logic_pipe.sv | 133 +++++++++++++
 tb/tb_logic_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_pipe_if.sv
// Operand/result handshake bundle for logic_pipe.
// The parity signal exists only when LOGIC_PIPE_PARITY_EN is defined.
interface logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ones;
    logic [15:0]      op_count;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, in0, in1, op, out_ready,
        input  in_ready, out_valid, out, zero, ones, op_count, parity
    );
    modport slave (
        input  in_valid, in0, in1, op, out_ready,
        output in_ready, out_valid, out, zero, ones, op_count, parity
    );
`else
    modport master (
        output in_valid, in0, in1, op, out_ready,
        input  in_ready, out_valid, out, zero, ones, op_count
    );
    modport slave (
        input  in_valid, in0, in1, op, out_ready,
        output in_ready, out_valid, out, zero, ones, op_count
    );
`endif
endinterface

// File: rtl/logic_pipe.sv
// Two-stage WIDTH-bit bitwise logic unit with valid/ready flow control.
// Optional registered parity output enabled by LOGIC_PIPE_PARITY_EN.
module logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    logic_pipe_if.slave  bus
);

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [15:0]      op_count_q, op_count_d;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] res;

    // in_ready is combinational from out_ready; there is no skid buffer.
    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        res = '0;
        unique case (s1_op_q)
            OP_NAND: res = ~(s1_a_q & s1_b_q);
            OP_AND:  res = s1_a_q & s1_b_q;
            OP_OR:   res = s1_a_q | s1_b_q;
            OP_NOR:  res = ~(s1_a_q | s1_b_q);
            OP_XOR:  res = s1_a_q ^ s1_b_q;
            OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
            OP_NOT:  res = ~s1_a_q;
            OP_PASS: res = s1_a_q;
            default: res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        op_count_d  = op_count_q;
`ifdef LOGIC_PIPE_PARITY_EN
        parity_d    = parity_q;
`endif
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d  = bus.in0;
                s1_b_d  = bus.in1;
                s1_op_d = bus.op;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d  = res;
                zero_d = (res == '0);
                ones_d = &res;
`ifdef LOGIC_PIPE_PARITY_EN
                parity_d = ^res;
`endif
            end
        end
        if (out_valid_q && bus.out_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= 3'b000;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            op_count_q  <= 16'd0;
`ifdef LOGIC_PIPE_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            op_count_q  <= op_count_d;
`ifdef LOGIC_PIPE_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.op_count  = op_count_q;
`ifdef LOGIC_PIPE_PARITY_EN
    assign bus.parity    = parity_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: results queued at input handshake,
// popped and compared at output handshake.
module tb_logic_pipe;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic rnd_rdy;

    logic_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk;
    int n_fail;
    logic [WIDTH-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0] o);
        case (o)
            3'd0: return ~(a & b);
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Output side: compare every consumed result against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("out", bus.out, e);
                check("zero", bus.zero, (e == '0));
                check("ones", bus.ones, &e);
`ifdef LOGIC_PIPE_PARITY_EN
                check("parity", bus.parity, ^e);
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] o, input logic [WIDTH-1:0] e);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in0 = a;
        bus.in1 = b;
        bus.op = o;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [15:0] base;
        logic [WIDTH-1:0] a, b;
        logic [2:0] o;
        sweep = '{8'hF5, 8'h0A, 8'hAF, 8'h50, 8'hA5, 8'h5A, 8'h55, 8'hAA};
        n_chk = 0;
        n_fail = 0;
        rnd_rdy = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.op = 3'b000;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_ones", bus.ones, 0);
        check("rst_op_count", bus.op_count, 0);
`ifdef LOGIC_PIPE_PARITY_EN
        check("rst_parity", bus.parity, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat and latency.
        send(8'hF0, 8'hCC, 3'b000, 8'h3F);
        @(negedge clk);
        check("lat_s1_only", bus.out_valid, 0);
        @(negedge clk);
        check("lat_valid", bus.out_valid, 1);
        check("lat_out", bus.out, 8'h3F);
        @(posedge clk);
        #1;
        drain();
        check("op_count_1", bus.op_count, 1);

        // Back-to-back sweep of all ops.
        base = bus.op_count;
        for (int i = 0; i < 8; i++) send(8'hAA, 8'h0F, 3'(i), sweep[i]);
        drain();
        check("op_count_sweep", bus.op_count, base + 16'd8);

        // Flags.
        send(8'hFF, 8'hFF, 3'b001, 8'hFF);
        send(8'hFF, 8'hFF, 3'b100, 8'h00);
        drain();

        // Backpressure: third beat must stall.
        base = bus.op_count;
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 3'b010, 8'h36);
        send(8'h12, 8'h34, 3'b001, 8'h10);
        bus.in_valid = 1'b1;
        bus.in0 = 8'h12;
        bus.in1 = 8'h34;
        bus.op = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_held", bus.out, 8'h36);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'h12, 8'h34, 3'b100, 8'h26);
        drain();
        check("bp_op_count", bus.op_count, base + 16'd3);

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        send(8'h01, 8'h02, 3'b010, 8'h03);
        send(8'h01, 8'h02, 3'b001, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_op_count", bus.op_count, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", bus.out_valid, 0);
        end
        check("post_rst_op_count", bus.op_count, 0);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        base = bus.op_count;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            send(a, b, o, model(a, b, o));
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();
        check("rnd_op_count", bus.op_count, base + 16'd40);

`ifdef LOGIC_PIPE_PARITY_EN
        send(8'h07, 8'h00, 3'b111, 8'h07);
        send(8'h03, 8'h00, 3'b111, 8'h03);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
